// File: rtl/bitserial_alu_sequencer.sv
// Bit-serial ALU: runs one structuralBitSlice LSB-first over WIDTH cycles, then publishes result and flags.
// Optional macro ALUSEQ_FLAGS_EN builds the carryout/overflow/zero flag logic; otherwise those outputs are tied 0.

module structuralBitSlice (
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       sum,
  output logic       carryout
);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;

  logic b_eff;
  logic half;

  // SUB and SLT add the inverted B with the carry chain seeded to 1
  assign b_eff = b ^ ((control == OP_SUB) || (control == OP_SLT));
  assign half  = a ^ b_eff;

  always_comb begin
    sum      = 1'b0;
    carryout = 1'b0;
    case (control)
      OP_ADD, OP_SUB, OP_SLT: begin
        sum      = half ^ carryin;
        carryout = (a & b_eff) | (carryin & half);
      end
      OP_XOR:  sum = a ^ b;
      OP_AND:  sum = a & b;
      OP_NAND: sum = ~(a & b);
      OP_NOR:  sum = ~(a | b);
      default: sum = a | b;
    endcase
  end
endmodule

module bitserial_alu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] res_next_c;
  logic             is_arith_c;
  logic             ovf_c;
  logic             slt_bit_c;

`ifdef ALUSEQ_FLAGS_EN
  logic carryout_q, carryout_d;
  logic overflow_q, overflow_d;
  logic zero_q, zero_d;
  logic cin_msb_c;
`endif

  structuralBitSlice u_slice (
    .a        (a_sr_q[0]),
    .b        (b_sr_q[0]),
    .carryin  (carry_q),
    .control  (cmd_q),
    .sum      (slice_sum),
    .carryout (slice_cout)
  );

  // On the last bit carry_q is the carry into the MSB, so overflow falls out directly
  assign res_next_c = {slice_sum, res_sr_q};
  assign is_arith_c = (cmd_q == OP_ADD) || (cmd_q == OP_SUB) || (cmd_q == OP_SLT);
  assign ovf_c      = carry_q ^ slice_cout;
  assign slt_bit_c  = slice_sum ^ ovf_c;
`ifdef ALUSEQ_FLAGS_EN
  assign cin_msb_c  = carry_q;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef ALUSEQ_FLAGS_EN
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = operandA;
          b_sr_d  = operandB;
          cmd_d   = command;
          cnt_d   = '0;
          carry_d = (command == OP_SUB) || (command == OP_SLT);
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy_d   = 1'b1;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_next_c[WIDTH-1:1];
        carry_d  = slice_cout;
        cnt_d    = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_BIT) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
          result_d = (cmd_q == OP_SLT) ? WIDTH'(slt_bit_c) : res_next_c;
`ifdef ALUSEQ_FLAGS_EN
          carryout_d = is_arith_c & slice_cout;
          overflow_d = is_arith_c & (cin_msb_c ^ slice_cout);
          zero_d     = (result_d == '0);
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cmd_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

`ifdef ALUSEQ_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign carryout = carryout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign carryout = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule
